// File: rtl/shift_deser_pkg.sv
// Shared types, constants and the shift helper for the serial deserializer.
package shift_deser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam bit ORDER_MSB = 1'b1;
    localparam bit ORDER_LSB = 1'b0;

    // Widest word the helper can handle; narrower words live in the low bits.
    localparam int MAX_W = 16;

    // Next shift-register value after capturing one bit into a width-bit word.
    // MSB-first shifts left and enters at bit 0; LSB-first shifts right and
    // enters at bit width-1. Bits above width-1 are always returned as zero.
    function automatic logic [MAX_W-1:0] bit_shift(input logic [MAX_W-1:0] sreg,
                                                    input logic             sin,
                                                    input logic             order,
                                                    input int               width);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] r;
        mask = {MAX_W{1'b1}} >> (MAX_W - width);
        if (order == ORDER_LSB)
            r = ((sreg & mask) >> 1) | (MAX_W'(sin) << (width - 1));
        else
            r = {sreg[MAX_W-2:0], sin};
        return r & mask;
    endfunction

endpackage

// File: rtl/deser_hold_stage.sv
// One-word output buffer with valid/ready handshake and overrun detection.
module deser_hold_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             drop
);

    // A new word is accepted when the buffer is empty or is being emptied on
    // this same edge; otherwise it is discarded and drop pulses.
    always_ff @(posedge clk) begin
        if (clr) begin
            out       <= '0;
            out_valid <= 1'b0;
            drop      <= 1'b0;
        end else begin
            drop <= 1'b0;
            if (load) begin
                if (!out_valid || ready) begin
                    out       <= data;
                    out_valid <= 1'b1;
                end else begin
                    drop <= 1'b1;
                end
            end else if (out_valid && ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/shift_deser_rx.sv
// Serial-in/parallel-out receiver: framed words in either bit order, handed
// to a one-word hold stage with a valid/ready output.
module shift_deser_rx
    import shift_deser_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             frame,
    input  logic             msb_first,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             overrun,
    output logic             frame_err
);

    if (WIDTH < 2 || WIDTH > MAX_W) begin : g_width_check
        $error("shift_deser_rx: WIDTH must be in 2..16");
    end

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic             order, order_n;
    logic             ferr_q, ferr_n;
    logic             load;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                   input logic             b,
                                                   input logic             ord);
        return WIDTH'(bit_shift(MAX_W'(cur), b, ord, WIDTH));
    endfunction

    // Control and shift state registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= IDLE;
            cnt    <= '0;
            sreg   <= '0;
            order  <= ORDER_MSB;
            ferr_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            sreg   <= sreg_n;
            order  <= order_n;
            ferr_q <= ferr_n;
        end
    end

    // Next-state: a frame bit always restarts from an empty word; the capture
    // that fills the word completes it and returns to IDLE on the same edge.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sreg_n  = sreg;
        order_n = order;
        ferr_n  = 1'b0;
        load    = 1'b0;
        if (sin_en) begin
            if (frame) begin
                order_n = msb_first;
                sreg_n  = shift_in('0, sin, msb_first);
                cnt_n   = CNT_ONE;
                state_n = SHIFT;
                ferr_n  = (state == SHIFT);
            end else if (state == SHIFT) begin
                sreg_n = shift_in(sreg, sin, order);
                cnt_n  = cnt + 1'b1;
            end
            if (cnt_n == CNT_FULL) begin
                load    = 1'b1;
                state_n = IDLE;
                cnt_n   = '0;
            end
        end
    end

    assign busy      = (state == SHIFT);
    assign bit_cnt   = cnt;
    assign frame_err = ferr_q;

    deser_hold_stage #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk      (clk),
        .clr      (clr),
        .load     (load),
        .data     (sreg_n),
        .ready    (out_ready),
        .out      (out),
        .out_valid(out_valid),
        .drop     (overrun)
    );

endmodule

// File: tb/tb_shift_deser_rx.sv
// Testbench for shift_deser_rx: directed scenarios plus random traffic,
// checked against a word-level reference model and an output scoreboard.
module tb_shift_deser_rx;
    import shift_deser_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             clr = 1'b1;
    logic             sin = 1'b0;
    logic             sin_en = 1'b0;
    logic             frame = 1'b0;
    logic             msb_first = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             busy;
    logic [CNT_W-1:0] bit_cnt;
    logic             overrun;
    logic             frame_err;

    int n_checks = 0;
    int n_err    = 0;

    shift_deser_rx #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .clr      (clr),
        .sin      (sin),
        .sin_en   (sin_en),
        .frame    (frame),
        .msb_first(msb_first),
        .out      (out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .bit_cnt  (bit_cnt),
        .overrun  (overrun),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (word level) ----------------
    logic             m_bits[$];
    logic             m_order;
    bit               m_active;
    bit               m_valid;
    logic [WIDTH-1:0] m_out;
    bit               m_ovr;
    bit               m_ferr;
    logic [WIDTH-1:0] exp_q[$];
    bit               m_hs;
    bit               m_done;
    logic [WIDTH-1:0] m_word;
    logic [WIDTH-1:0] m_fold;

    always @(posedge clk) begin
        if (clr) begin
            m_bits.delete();
            exp_q.delete();
            m_order  = 1'b1;
            m_active = 0;
            m_valid  = 0;
            m_out    = '0;
            m_ovr    = 0;
            m_ferr   = 0;
        end else begin
            m_ovr  = 0;
            m_ferr = 0;
            m_done = 0;
            m_hs   = m_valid && out_ready;
            if (sin_en) begin
                if (frame) begin
                    m_ferr   = m_active;
                    m_bits.delete();
                    m_bits.push_back(sin);
                    m_order  = msb_first;
                    m_active = 1;
                end else if (m_active) begin
                    m_bits.push_back(sin);
                end
                if (m_active && m_bits.size() == WIDTH) begin
                    // First received bit is the MSB (MSB-first) or LSB (LSB-first).
                    m_word = '0;
                    m_fold = '0;
                    for (int i = 0; i < WIDTH; i++) begin
                        if (m_order) m_word[WIDTH-1-i] = m_bits[i];
                        else         m_word[i]         = m_bits[i];
                        m_fold = WIDTH'(bit_shift(16'(m_fold), m_bits[i], m_order, WIDTH));
                    end
                    chk("bit_shift_fn", 32'(m_fold), 32'(m_word));
                    m_bits.delete();
                    m_active = 0;
                    m_done   = 1;
                end
            end
            if (m_done) begin
                if (!m_valid || m_hs) begin
                    m_valid = 1;
                    m_out   = m_word;
                    exp_q.push_back(m_word);
                end else begin
                    m_ovr = 1;
                end
            end else if (m_hs) begin
                m_valid = 0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out",       32'(out),       32'(m_out));
        chk("busy",      32'(busy),      32'(m_active));
        chk("bit_cnt",   32'(bit_cnt),   32'(m_bits.size()));
        chk("overrun",   32'(overrun),   32'(m_ovr));
        chk("frame_err", 32'(frame_err), 32'(m_ferr));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL sb_pop: handshake with out=%0h but no word expected at %0t", out, $time);
            end else begin
                chk("sb_word", 32'(out), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic f, input logic m);
        sin_en    = 1'b1;
        sin       = b;
        frame     = f;
        msb_first = m;
        step();
        sin_en = 1'b0;
        frame  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input logic m);
        for (int i = 0; i < WIDTH; i++)
            send_bit(m ? w[WIDTH-1-i] : w[i], i == 0, m);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        int pos;
        clr = 1'b1;
        idle(2);
        clr = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out",       32'(out),       32'd0);
        chk("rst_bit_cnt",   32'(bit_cnt),   32'd0);
        chk("rst_busy",      32'(busy),      32'd0);

        // MSB-first word 1,0,1,1
        send_word(4'b1011, 1'b1);
        chk("t1_out",     32'(out),       32'hB);
        chk("t1_valid",   32'(out_valid), 32'd1);
        chk("t1_busy",    32'(busy),      32'd0);
        chk("t1_bit_cnt", 32'(bit_cnt),   32'd0);
        drain();

        // LSB-first, msb_first toggled on non-frame bits
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0, 1'b1);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b1);
        chk("t2_out", 32'(out), 32'hD);
        drain();

        // overrun while a word is held
        send_word(4'b0110, 1'b1);
        send_word(4'b1001, 1'b1);
        chk("t3_overrun", 32'(overrun), 32'd1);
        chk("t3_out",     32'(out),     32'h6);
        drain();
        chk("t3_valid_clr", 32'(out_valid), 32'd0);

        // handshake on the same edge as a completion
        send_word(4'b0110, 1'b1);
        send_bit(1'b0, 1'b1, 1'b1);
        send_bit(1'b0, 1'b0, 1'b1);
        send_bit(1'b1, 1'b0, 1'b1);
        out_ready = 1'b1;
        send_bit(1'b1, 1'b0, 1'b1);
        chk("t4_out",     32'(out),       32'h3);
        chk("t4_valid",   32'(out_valid), 32'd1);
        chk("t4_overrun", 32'(overrun),   32'd0);
        drain();

        // frame error mid-word, restart
        send_bit(1'b1, 1'b1, 1'b1);
        send_bit(1'b0, 1'b0, 1'b1);
        send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b1, 1'b1, 1'b1);
        chk("t5_frame_err", 32'(frame_err), 32'd1);
        chk("t5_bit_cnt",   32'(bit_cnt),   32'd1);
        send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b1, 1'b0, 1'b1);
        chk("t5_out", 32'(out), 32'hF);
        drain();

        // gaps between bits, then reset mid-word
        send_bit(1'b1, 1'b1, 1'b1); idle(3);
        send_bit(1'b0, 1'b0, 1'b1); idle(3);
        send_bit(1'b1, 1'b0, 1'b1); idle(3);
        send_bit(1'b0, 1'b0, 1'b1);
        chk("t6_gap_out", 32'(out), 32'hA);
        drain();
        send_bit(1'b1, 1'b1, 1'b1); idle(3);
        send_bit(1'b1, 1'b0, 1'b1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t6_clr_out",     32'(out),       32'd0);
        chk("t6_clr_valid",   32'(out_valid), 32'd0);
        chk("t6_clr_busy",    32'(busy),      32'd0);
        chk("t6_clr_bit_cnt", 32'(bit_cnt),   32'd0);
        send_word(4'b0101, 1'b1);
        chk("t6_after_clr", 32'(out), 32'h5);
        drain();

        // random traffic
        pos = 0;
        for (int c = 0; c < 3000; c++) begin
            clr       = ($urandom_range(199) == 0);
            sin_en    = ($urandom_range(3) != 0);
            sin       = 1'($urandom);
            msb_first = 1'($urandom);
            out_ready = 1'($urandom);
            frame     = (pos == 0) ? ($urandom_range(3) != 0) : ($urandom_range(15) == 0);
            if (clr) pos = 0;
            else if (sin_en && frame) pos = 1;
            else if (sin_en && pos > 0) pos++;
            if (pos == WIDTH) pos = 0;
            step();
        end
        clr = 1'b0;
        sin_en = 1'b0;
        frame = 1'b0;
        out_ready = 1'b1;
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
